// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared encodings, state enum and defaults for the memory access sequencer
package mem_seq_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int DEF_MEM_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_RSP,
        ST_ERR
    } state_t;

    // Reserved size 2'b11 is folded into the misalign path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - request, memory and response signals of the sequencer
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_misalign;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_rdata, rsp_misalign
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_rdata, rsp_misalign
    );

endinterface

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - little-endian lane extract/extend for loads and lane merge for stores
module byte_lane_unit
    import mem_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [15:0] lane_h;
    logic [7:0]  lane_b;

    always_comb begin
        load_data = rdata;
        merged    = wdata;
        lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        lane_b    = rdata[{addr_lo, 3'b000} +: 8];
        case (size)
            SZ_HALF: begin
                load_data = {{16{is_signed & lane_h[15]}}, lane_h};
                merged    = rdata;
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            SZ_BYTE: begin
                load_data = {{24{is_signed & lane_b[7]}}, lane_b};
                merged    = rdata;
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - one-at-a-time load/store sequencer with latency wait, RMW and misalign reject
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_access_sequencer_if.slave   bus
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;

    byte_lane_unit u_lane (
        .size      (size_q),
        .addr_lo   (addr_lo_q),
        .is_signed (signed_q),
        .rdata     (bus.mem_rdata),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            wr_q             <= 1'b0;
            size_q           <= SZ_WORD;
            signed_q         <= 1'b0;
            addr_lo_q        <= 2'b00;
            wdata_q          <= '0;
            bus.req_ready    <= 1'b1;
            bus.mem_addr     <= '0;
            bus.mem_wr       <= 1'b0;
            bus.mem_wdata    <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_misalign <= 1'b0;
        end else begin
            bus.mem_wr       <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q          <= bus.req_write;
                        size_q        <= bus.req_size;
                        signed_q      <= bus.req_signed;
                        addr_lo_q     <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state            <= ST_ERR;
                            bus.rsp_valid    <= 1'b1;
                            bus.rsp_misalign <= 1'b1;
                        end else begin
                            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            cnt          <= '0;
                            // Full-word stores skip the read phase entirely.
                            if (bus.req_write && bus.req_size == SZ_WORD) begin
                                state         <= ST_WR;
                                bus.mem_wr    <= 1'b1;
                                bus.mem_wdata <= bus.req_wdata;
                            end else begin
                                state <= ST_RD_WAIT;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (wr_q) begin
                            state         <= ST_WR;
                            bus.mem_wr    <= 1'b1;
                            bus.mem_wdata <= lane_merged;
                        end else begin
                            state         <= ST_RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= lane_load;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    state <= ST_WR_WAIT;
                    cnt   <= '0;
                end
                ST_WR_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state         <= ST_RSP;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer at latency 3 and 1
module tb_mem_access_sequencer;

    typedef struct {
        bit          mis;
        int          rsp_cyc;
        int          wr_cyc;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cur;
    logic        rv, rw, rs;
    logic [1:0]  rsz;
    logic [31:0] ra, rwd;

    logic [31:0] mem3 [64];
    logic [31:0] mem1 [64];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    bit   active;
    bit   done;
    exp_t e;
    logic [31:0] exp_addr;

    mem_access_sequencer_if #(.ADDR_W(32)) bus3 ();
    mem_access_sequencer_if #(.ADDR_W(32)) bus1 ();

    mem_access_sequencer #(.ADDR_W(32), .MEM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    mem_access_sequencer #(.ADDR_W(32), .MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus3.req_valid  = rv & ~cur;
    assign bus3.req_write  = rw;
    assign bus3.req_size   = rsz;
    assign bus3.req_signed = rs;
    assign bus3.req_addr   = ra;
    assign bus3.req_wdata  = rwd;
    assign bus3.mem_rdata  = mem3[bus3.mem_addr[7:2]];

    assign bus1.req_valid  = rv & cur;
    assign bus1.req_write  = rw;
    assign bus1.req_size   = rsz;
    assign bus1.req_signed = rs;
    assign bus1.req_addr   = ra;
    assign bus1.req_wdata  = rwd;
    assign bus1.mem_rdata  = mem1[bus1.mem_addr[7:2]];

    wire        o_ready    = cur ? bus1.req_ready    : bus3.req_ready;
    wire        o_mem_wr   = cur ? bus1.mem_wr       : bus3.mem_wr;
    wire [31:0] o_mem_addr = cur ? bus1.mem_addr     : bus3.mem_addr;
    wire [31:0] o_mem_wd   = cur ? bus1.mem_wdata    : bus3.mem_wdata;
    wire        o_rsp_v    = cur ? bus1.rsp_valid    : bus3.rsp_valid;
    wire [31:0] o_rsp_d    = cur ? bus1.rsp_rdata    : bus3.rsp_rdata;
    wire        o_rsp_mis  = cur ? bus1.rsp_misalign : bus3.rsp_misalign;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'h8899AABB;
            8:       return 32'h11223344;
            default: return 32'h0;
        endcase
    endfunction

    // Memory contents are re-seeded whenever reset is held low.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                mem3[i] <= init_word(i);
                mem1[i] <= init_word(i);
            end
        end else begin
            if (bus3.mem_wr) mem3[bus3.mem_addr[7:2]] <= bus3.mem_wdata;
            if (bus1.mem_wr) mem1[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one access, from the size/alignment/latency rules.
    function automatic exp_t model(input bit w, input logic [1:0] sz, input bit sg,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] old, input int lat);
        exp_t   r;
        int     nb, sh;
        longint mask, v, ov, wv;
        r.mis    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0);
        r.wr_cyc = -1;
        r.wdata  = '0;
        r.rdata  = '0;
        r.rsp_cyc = 1;
        if (r.mis) return r;
        nb   = (sz == 2'd0) ? 32 : (sz == 2'd1) ? 16 : 8;
        sh   = (sz == 2'd0) ? 0 : (sz == 2'd1) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        mask = (64'sd1 <<< nb) - 1;
        ov   = longint'(old);
        wv   = longint'(wd);
        if (!w) begin
            v = (ov >> sh) & mask;
            if (sg && nb < 32 && v[nb-1]) v = v - (64'sd1 <<< nb);
            r.rdata   = v[31:0];
            r.rsp_cyc = lat + 1;
        end else if (sz == 2'd0) begin
            r.wr_cyc  = 1;
            r.wdata   = wd;
            r.rsp_cyc = lat + 2;
        end else begin
            v = (ov & ~(mask << sh)) | ((wv & mask) << sh);
            r.wdata   = v[31:0];
            r.wr_cyc  = lat + 1;
            r.rsp_cyc = 2 * lat + 2;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (active) begin
            cyc = cyc + 1;
            check("mem_wr", {31'b0, o_mem_wr}, {31'b0, cyc == e.wr_cyc});
            if (cyc == e.wr_cyc) check("mem_wdata", o_mem_wd, e.wdata);
            check("rsp_valid", {31'b0, o_rsp_v}, {31'b0, cyc == e.rsp_cyc});
            if (cyc == e.rsp_cyc) begin
                check("rsp_misalign", {31'b0, o_rsp_mis}, {31'b0, e.mis});
                check("rsp_rdata", o_rsp_d, e.rdata);
            end
            if (!e.mis && cyc <= e.rsp_cyc) check("mem_addr", o_mem_addr, exp_addr);
            check("req_ready", {31'b0, o_ready}, {31'b0, cyc > e.rsp_cyc});
            if (cyc > e.rsp_cyc) begin
                active = 1'b0;
                done   = 1'b1;
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 of the first idle cycle after the response.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] old;
        old      = cur ? mem1[a[7:2]] : mem3[a[7:2]];
        e        = model(w, sz, sg, a, wd, old, cur ? 1 : 3);
        exp_addr = {a[31:2], 2'b00};
        rw = w; rsz = sz; rs = sg; ra = a; rwd = wd; rv = 1'b1;
        @(posedge clk);
        #1;
        rv = 1'b0; cyc = 0; done = 1'b0; active = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        check("req_completes", {31'b0, done}, 32'd1);
        active = 1'b0;
    endtask

    initial begin
        exp_t p;
        active = 1'b0; done = 1'b0; cyc = 0; cur = 1'b0;
        rv = 1'b0; rw = 1'b0; rs = 1'b0; rsz = 2'd0; ra = '0; rwd = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready3", {31'b0, bus3.req_ready}, 32'd1);
        check("rst_memwr3", {31'b0, bus3.mem_wr}, 32'd0);
        check("rst_addr3", bus3.mem_addr, 32'd0);
        check("rst_rspv3", {31'b0, bus3.rsp_valid}, 32'd0);
        check("rst_ready1", {31'b0, bus1.req_ready}, 32'd1);
        reset = 1'b1;
        #1;

        p = model(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 3);
        check("pin_lw_rdata", p.rdata, 32'h8899AABB);
        check("pin_lw_cyc", p.rsp_cyc, 4);
        p = model(1'b0, 2'd2, 1'b1, 32'h13, 32'h0, 32'h8899AABB, 3);
        check("pin_lb_rdata", p.rdata, 32'hFFFFFF88);
        p = model(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h8899AABB, 3);
        check("pin_lhu_rdata", p.rdata, 32'h00008899);
        p = model(1'b1, 2'd2, 1'b0, 32'h21, 32'hCC, 32'h11223344, 3);
        check("pin_sb_wdata", p.wdata, 32'h1122CC44);
        check("pin_sb_wcyc", p.wr_cyc, 4);
        check("pin_sb_rcyc", p.rsp_cyc, 8);
        p = model(1'b1, 2'd0, 1'b0, 32'h30, 32'hDEADBEEF, 32'h0, 3);
        check("pin_sw_cyc", p.rsp_cyc, 5);
        check("pin_sw_wcyc", p.wr_cyc, 1);
        p = model(1'b1, 2'd1, 1'b0, 32'h31, 32'h0, 32'h0, 3);
        check("pin_sh_mis", {31'b0, p.mis}, 32'd1);
        p = model(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0, 1);
        check("pin_l1_lw", p.rsp_cyc, 2);
        p = model(1'b1, 2'd2, 1'b0, 32'h21, 32'hCC, 32'h0, 1);
        check("pin_l1_sb", p.rsp_cyc, 4);

        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b1, 32'h13, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h21, 32'hCC);
        check("mem_after_sb", mem3[8], 32'h1122CC44);
        do_req(1'b1, 2'd0, 1'b0, 32'h30, 32'hDEADBEEF);
        do_req(1'b1, 2'd1, 1'b0, 32'h31, 32'h1234);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555ABCD);
        do_req(1'b0, 2'd0, 1'b0, 32'h30, 32'h0);
        check("mem_after_sh", mem3[8], 32'hABCDCC44);
        check("mem_after_sw", mem3[12], 32'hDEADBEEF);

        // Abort an SW in its WR_WAIT phase.
        rw = 1'b1; rsz = 2'd0; rs = 1'b0; ra = 32'h30; rwd = 32'hDEADBEEF; rv = 1'b1;
        @(posedge clk);
        #1 rv = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_ready", {31'b0, bus3.req_ready}, 32'd1);
        check("abort_memwr", {31'b0, bus3.mem_wr}, 32'd0);
        check("abort_addr", bus3.mem_addr, 32'd0);
        check("abort_wdata", bus3.mem_wdata, 32'd0);
        check("abort_rspv", {31'b0, bus3.rsp_valid}, 32'd0);
        check("abort_rspd", bus3.rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_abort_rspv", {31'b0, bus3.rsp_valid}, 32'd0);
            check("post_abort_ready", {31'b0, bus3.req_ready}, 32'd1);
        end
        #1;
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);

        cur = 1'b1;
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h21, 32'hCC);
        do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h31, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h14, 32'hCAFEF00D);
        do_req(1'b0, 2'd2, 1'b1, 32'h17, 32'h0);
        check("l1_mem_sb", mem1[8], 32'h1122CC44);
        check("l1_mem_sw", mem1[5], 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
